// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: RISC-V immediate generator feeding the ID/EX boundary.
// Covers the I/S/B/J/U formats and the CSR zimm, then registers the result
// through STAGES pipeline stages that support stall and flush.
module imm_extend_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     Instr,
    input  logic [2:0]      ImmSrc,
    input  logic            stall,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] ImmExt,
    output logic            illegal
);

    // Only the two widths and the two depths below are supported.
    generate
        if (!((XLEN == 32 || XLEN == 64) && (STAGES == 1 || STAGES == 2))) begin : g_cfg_err
            $error("imm_extend_pipe: XLEN must be 32/64 and STAGES must be 1/2");
        end
    endgenerate

    logic [XLEN-1:0] imm_comb;
    logic            ill_comb;

    // The opcode field never contributes to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^Instr[6:0];

    // Decode the immediate; the signed casts replicate Instr[31] up to XLEN-1.
    // For U-type on XLEN=32 the cast is a no-op, on XLEN=64 it sign-fills 63:32.
    always_comb begin
        imm_comb = '0;
        ill_comb = 1'b0;
        case (ImmSrc)
            3'b000: imm_comb = XLEN'($signed(Instr[31:20]));
            3'b001: imm_comb = XLEN'($signed({Instr[31:25], Instr[11:7]}));
            3'b010: imm_comb = XLEN'($signed({Instr[31], Instr[7], Instr[30:25],
                                              Instr[11:8], 1'b0}));
            3'b011: imm_comb = XLEN'($signed({Instr[31], Instr[19:12], Instr[20],
                                              Instr[30:21], 1'b0}));
            3'b100: imm_comb = XLEN'($signed({Instr[31:12], 12'b0}));
            3'b101: imm_comb = XLEN'(Instr[19:15]);
            default: ill_comb = 1'b1;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : stage_g
            logic            valid_q, valid_d;
            logic [XLEN-1:0] imm_q, imm_d;
            logic            ill_q, ill_d;
            logic            src_valid;
            logic [XLEN-1:0] src_imm;
            logic            src_ill;

            if (gi == 0) begin : g_src_in
                assign src_valid = in_valid;
                assign src_imm   = imm_comb;
                assign src_ill   = ill_comb;
            end else begin : g_src_prev
                assign src_valid = stage_g[gi-1].valid_q;
                assign src_imm   = stage_g[gi-1].imm_q;
                assign src_ill   = stage_g[gi-1].ill_q;
            end

            // Next state: flush clears, stall holds, otherwise shift in (zeroed when invalid).
            always_comb begin
                valid_d = valid_q;
                imm_d   = imm_q;
                ill_d   = ill_q;
                if (flush) begin
                    valid_d = 1'b0;
                    imm_d   = '0;
                    ill_d   = 1'b0;
                end else if (!stall) begin
                    valid_d = src_valid;
                    imm_d   = src_valid ? src_imm : '0;
                    ill_d   = src_valid & src_ill;
                end
            end

            // Stage register; reset overrides flush and stall.
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    imm_q   <= '0;
                    ill_q   <= 1'b0;
                end else begin
                    valid_q <= valid_d;
                    imm_q   <= imm_d;
                    ill_q   <= ill_d;
                end
            end
        end
    endgenerate

    assign out_valid = stage_g[STAGES-1].valid_q;
    assign ImmExt    = stage_g[STAGES-1].imm_q;
    assign illegal   = stage_g[STAGES-1].ill_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: three instances (32/1, 64/1, 32/2) share stimulus.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic [31:0] Instr;
    logic [2:0]  ImmSrc;

    logic        v1, il1, v64, il64, v2, il2;
    logic [31:0] imm1, imm2;
    logic [63:0] imm64;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .STAGES(1)) d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .Instr(Instr), .ImmSrc(ImmSrc),
        .stall(stall), .flush(flush), .out_valid(v1), .ImmExt(imm1), .illegal(il1));
    imm_extend_pipe #(.XLEN(64), .STAGES(1)) d64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .Instr(Instr), .ImmSrc(ImmSrc),
        .stall(stall), .flush(flush), .out_valid(v64), .ImmExt(imm64), .illegal(il64));
    imm_extend_pipe #(.XLEN(32), .STAGES(2)) d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .Instr(Instr), .ImmSrc(ImmSrc),
        .stall(stall), .flush(flush), .out_valid(v2), .ImmExt(imm2), .illegal(il2));

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic        vld;
        logic [31:0] e32;
        logic [63:0] e64;
        logic        eill;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic st, input logic fl, input logic rs);
        in_valid = v; Instr = ins; ImmSrc = src; stall = st; flush = fl; reset = rs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_d2(input string tag, input logic v, input logic [31:0] imm, input logic il);
        chk({tag, "_d2_valid"}, 64'(v2), 64'(v));
        chk({tag, "_d2_imm"}, 64'(imm2), 64'(imm));
        chk({tag, "_d2_ill"}, 64'(il2), 64'(il));
        $display("txn %s: d2 valid=%0b imm=0x%08h ill=%0b", tag, v2, imm2, il2);
    endtask

    initial begin
        vec_t prev;

        vt[0]  = '{32'hFFF00093, 3'b000, 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vt[1]  = '{32'hFE112E23, 3'b001, 1'b1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vt[2]  = '{32'hFE000CE3, 3'b010, 1'b1, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
        vt[3]  = '{32'h004000EF, 3'b011, 1'b1, 32'h00000004, 64'h0000000000000004, 1'b0};
        vt[4]  = '{32'h123450B7, 3'b100, 1'b1, 32'h12345000, 64'h0000000012345000, 1'b0};
        vt[5]  = '{32'h0002D073, 3'b101, 1'b1, 32'h00000005, 64'h0000000000000005, 1'b0};
        vt[6]  = '{32'h800000B7, 3'b100, 1'b1, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vt[7]  = '{32'hDEADBEEF, 3'b110, 1'b1, 32'h00000000, 64'h0000000000000000, 1'b1};
        vt[8]  = '{32'hFFF00093, 3'b000, 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vt[9]  = '{32'h12345678, 3'b000, 1'b0, 32'h00000000, 64'h0000000000000000, 1'b0};
        vt[10] = '{32'h00100093, 3'b000, 1'b1, 32'h00000001, 64'h0000000000000001, 1'b0};
        vt[11] = '{32'hFFFFFFFF, 3'b111, 1'b1, 32'h00000000, 64'h0000000000000000, 1'b1};

        // Reset state.
        drive(1'b1, 32'hFFF00093, 3'b000, 1'b0, 1'b0, 1'b1);
        step(); step();
        chk("rst_d1_valid", 64'(v1), 64'd0);
        chk("rst_d1_imm", 64'(imm1), 64'd0);
        chk("rst_d64_imm", imm64, 64'd0);
        chk_d2("rst", 1'b0, 32'd0, 1'b0);

        // Table sweep: one instruction per edge; d2 trails by one edge.
        prev = '{32'd0, 3'd0, 1'b0, 32'd0, 64'd0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].vld, vt[i].instr, vt[i].src, 1'b0, 1'b0, 1'b0);
            step();
            chk($sformatf("vec%0d_d1_valid", i), 64'(v1), 64'(vt[i].vld));
            chk($sformatf("vec%0d_d1_imm", i), 64'(imm1), 64'(vt[i].e32));
            chk($sformatf("vec%0d_d1_ill", i), 64'(il1), 64'(vt[i].eill));
            chk($sformatf("vec%0d_d64_valid", i), 64'(v64), 64'(vt[i].vld));
            chk($sformatf("vec%0d_d64_imm", i), imm64, vt[i].e64);
            chk($sformatf("vec%0d_d64_ill", i), 64'(il64), 64'(vt[i].eill));
            chk($sformatf("vec%0d_d2_valid", i), 64'(v2), 64'(prev.vld));
            chk($sformatf("vec%0d_d2_imm", i), 64'(imm2), 64'(prev.e32));
            chk($sformatf("vec%0d_d2_ill", i), 64'(il2), 64'(prev.eill));
            $display("txn vec%0d: instr=0x%08h src=%0d d1=0x%08h d64=0x%016h ill=%0b valid=%0b",
                     i, vt[i].instr, vt[i].src, imm1, imm64, il1, v1);
            prev = vt[i];
        end

        // Stall: A in stage 2, B in stage 1, three-cycle stall, then B, then C.
        drive(1'b0, 32'd0, 3'b000, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hFFF00093, 3'b000, 1'b0, 1'b0, 1'b0);   // A = -1
        step();
        drive(1'b1, 32'h123450B7, 3'b100, 1'b0, 1'b0, 1'b0);   // B = 0x12345000
        step();
        chk_d2("stall_pre_A", 1'b1, 32'hFFFFFFFF, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h0002D073, 3'b101, 1'b1, 1'b0, 1'b0); // C presented, ignored
            step();
            chk_d2($sformatf("stall_hold%0d", k), 1'b1, 32'hFFFFFFFF, 1'b0);
            chk($sformatf("stall_hold%0d_d1", k), 64'(imm1), 64'h12345000);
        end
        drive(1'b1, 32'h0002D073, 3'b101, 1'b0, 1'b0, 1'b0);   // C = 5
        step();
        chk_d2("stall_post_B", 1'b1, 32'h12345000, 1'b0);
        drive(1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        chk_d2("stall_post_C", 1'b1, 32'h00000005, 1'b0);

        // Flush together with stall: A, B in flight, C lost, no leakage.
        drive(1'b1, 32'hFFF00093, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h123450B7, 3'b100, 1'b0, 1'b0, 1'b0);
        step();
        chk_d2("flush_pre_A", 1'b1, 32'hFFFFFFFF, 1'b0);
        drive(1'b1, 32'h0002D073, 3'b101, 1'b1, 1'b1, 1'b0);
        step();
        chk_d2("flush_e1", 1'b0, 32'd0, 1'b0);
        chk("flush_e1_d1_valid", 64'(v1), 64'd0);
        drive(1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        chk_d2("flush_e2", 1'b0, 32'd0, 1'b0);

        // Reset mid-stream with stages full, stall also high.
        drive(1'b1, 32'hFFF00093, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hDEADBEEF, 3'b110, 1'b0, 1'b0, 1'b0);
        step();
        chk_d2("mid_pre", 1'b1, 32'hFFFFFFFF, 1'b0);
        chk("mid_pre_d1_ill", 64'(il1), 64'd1);
        drive(1'b1, 32'h0002D073, 3'b101, 1'b1, 1'b0, 1'b1);
        step();
        chk_d2("mid_rst", 1'b0, 32'd0, 1'b0);
        chk("mid_rst_d1_valid", 64'(v1), 64'd0);
        chk("mid_rst_d1_ill", 64'(il1), 64'd0);
        chk("mid_rst_d64_imm", imm64, 64'd0);
        drive(1'b1, 32'h00100093, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        chk("rel_e1_d1_valid", 64'(v1), 64'd1);
        chk("rel_e1_d1_imm", 64'(imm1), 64'd1);
        chk_d2("rel_e1", 1'b0, 32'd0, 1'b0);
        drive(1'b0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        chk_d2("rel_e2", 1'b1, 32'd1, 1'b0);
        chk("rel_e2_d1_valid", 64'(v1), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
